dram_controller: RTL and testbench

- Memory controller between the L2 cache and a DRAM bank model.
- Queues L2 read/write requests in an internal FIFO (l2_req_buffer), decodes each address into bank/row/column, and issues ACTIVATE then READ/WRITE commands to DRAM over a 4-phase req/ack handshake.
- Drives data to, and samples data from, a bidirectional DRAM data bus; returns read data to L2.

---
 rtl/dram_controller.sv | 144 ++++++++++++++
 tb/tb_dram_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dram_controller.sv
`timescale 1ns/1ps
// L2-to-DRAM bank controller: FIFO-buffered requests, each issued as ACTIVATE then READ/WRITE
// over a 4-phase req/ack handshake (closed page, strictly in order).
module dram_controller #(
  parameter int L2_REQ_WIDTH   = 22,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_OF_BANKS   = 8,
  parameter int NUM_OF_ROWS    = 128,
  parameter int NUM_OF_COLS    = 8,
  parameter int CONCAT_ADDRESS = 20,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    l2_rw_req,
  input  logic [L2_REQ_WIDTH-1:0] l2_req_instr,
  input  logic [DATA_WIDTH-1:0]   l2_req_data,
  input  logic                    cmd_ack,
  output logic                    cmd_req,
  output logic [1:0]              cmd,
  output logic [NUM_OF_BANKS-1:0] bank_sel,
  output logic [NUM_OF_ROWS-1:0]  row_sel,
  output logic [NUM_OF_COLS-1:0]  col_sel,
  output logic                    bank_rw,
  output logic                    buf_rw,
  output logic [DATA_WIDTH-1:0]   l2_rsp_data,
  inout  wire  [DATA_WIDTH-1:0]   dram_data
);

  localparam int BANK_W = $clog2(NUM_OF_BANKS);
  localparam int ROW_W  = $clog2(NUM_OF_ROWS);
  localparam int COL_W  = $clog2(NUM_OF_COLS);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int EW     = 1 + L2_REQ_WIDTH + DATA_WIDTH;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] POP     = 3'd1;
  localparam logic [2:0] ACT     = 3'd2;
  localparam logic [2:0] ACT_REL = 3'd3;
  localparam logic [2:0] RW      = 3'd4;
  localparam logic [2:0] RW_REL  = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [AW:0]             wr_ptr_q, rd_ptr_q;
  logic [L2_REQ_WIDTH-1:0] last_instr_q;
  logic                    wr_en, rd_en, empty, full;
  logic [EW-1:0]           l2_buffer_out;
  logic [L2_REQ_WIDTH-1:0] head_instr;
  logic [BANK_W-1:0]       bank_id, bank_q;
  logic [ROW_W-1:0]        row_id, row_q;
  logic [COL_W-1:0]        col_id, col_q;
  logic                    op_q;
  logic [DATA_WIDTH-1:0]   data_q, rsp_q;
  logic                    sel_active, rw_phase, drv_en;
  logic                    unused_instr_bits;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en = (state_q == POP);
  // A full FIFO still accepts a write in the same cycle a pop frees a slot.
  assign wr_en = (l2_req_instr != last_instr_q) && (!full || rd_en);
  assign l2_buffer_out = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {l2_rw_req, l2_req_instr, l2_req_data};
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_instr_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q     <= wr_ptr_q + (AW+1)'(1);
        last_instr_q <= l2_req_instr;
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  assign head_instr = l2_buffer_out[DATA_WIDTH +: L2_REQ_WIDTH];
  assign col_id     = head_instr[COL_W-1:0];
  assign row_id     = head_instr[COL_W +: ROW_W];
  assign bank_id    = head_instr[COL_W+ROW_W +: BANK_W];
  assign unused_instr_bits = ^head_instr[L2_REQ_WIDTH-1:COL_W+ROW_W+BANK_W];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty)  state_d = POP;
      POP:                  state_d = ACT;
      ACT:     if (cmd_ack) state_d = ACT_REL;
      ACT_REL: if (!cmd_ack) state_d = RW;
      RW:      if (cmd_ack) state_d = RW_REL;
      RW_REL:  if (!cmd_ack) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == POP) begin
        op_q   <= l2_buffer_out[EW-1];
        bank_q <= bank_id;
        row_q  <= row_id;
        col_q  <= col_id;
        data_q <= l2_buffer_out[DATA_WIDTH-1:0];
      end
      if (state_q == RW && !op_q && cmd_ack) rsp_q <= dram_data;
    end
  end

  assign sel_active = (state_q == ACT) || (state_q == ACT_REL) || (state_q == RW) || (state_q == RW_REL);
  assign rw_phase   = (state_q == RW) || (state_q == RW_REL);
  assign drv_en     = rw_phase && op_q;

  assign cmd_req = (state_q == ACT) || (state_q == RW);

  always_comb begin
    cmd = 2'b00;
    if (state_q == ACT || state_q == ACT_REL) cmd = 2'b01;
    else if (rw_phase)                        cmd = op_q ? 2'b11 : 2'b10;
  end

  assign bank_sel    = sel_active ? (NUM_OF_BANKS'(1) << bank_q) : '0;
  assign row_sel     = sel_active ? (NUM_OF_ROWS'(1) << row_q)   : '0;
  assign col_sel     = sel_active ? (NUM_OF_COLS'(1) << col_q)   : '0;
  assign bank_rw     = drv_en;
  assign buf_rw      = drv_en;
  assign l2_rsp_data = rsp_q;
  assign dram_data   = drv_en ? data_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_dram_controller.sv
`timescale 1ns/1ps
// Directed bench for dram_controller: a behavioural bank model answers each handshake
// after a programmable delay and stores/echoes data per bank/row/column.
module tb_dram_controller;
  logic         clk = 1'b0;
  logic         rst_b, l2_rw_req, cmd_ack;
  logic [21:0]  l2_req_instr;
  logic [7:0]   l2_req_data;
  logic         cmd_req;
  logic [1:0]   cmd;
  logic [7:0]   bank_sel;
  logic [127:0] row_sel;
  logic [7:0]   col_sel;
  logic         bank_rw, buf_rw;
  logic [7:0]   l2_rsp_data;
  wire  [7:0]   dram_data;
  logic         tb_drv;
  logic [7:0]   tb_dat;
  int           checks = 0;
  int           failures = 0;
  int           wr_cnt = 0;
  int           base;
  logic [7:0]   bank_mem [int];

  assign dram_data = tb_drv ? tb_dat : 8'hzz;

  dram_controller dut (
    .clk(clk), .rst_b(rst_b), .l2_rw_req(l2_rw_req), .l2_req_instr(l2_req_instr),
    .l2_req_data(l2_req_data), .cmd_ack(cmd_ack), .cmd_req(cmd_req), .cmd(cmd),
    .bank_sel(bank_sel), .row_sel(row_sel), .col_sel(col_sel), .bank_rw(bank_rw),
    .buf_rw(buf_rw), .l2_rsp_data(l2_rsp_data), .dram_data(dram_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst_b && dut.wr_en) wr_cnt++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic lvl, input string tag);
    int n = 0;
    @(negedge clk);
    while (cmd_req !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " req wait"}, 128'(cmd_req), 128'(lvl));
  endtask

  // Bank model: completes one ACTIVATE + READ/WRITE exchange, acking dly ns after each edge of cmd_req.
  task automatic serve(input logic [21:0] instr, input logic wr, input logic [7:0] wd,
                       input int dly, input string tag);
    logic [2:0] b, c;
    logic [6:0] r;
    int key;
    c = instr[2:0];
    r = instr[9:3];
    b = instr[12:10];
    key = 32'({b, r, c});
    wait_req(1'b1, {tag, " act"});
    chk({tag, " act cmd"}, 128'(cmd), 128'(2'b01));
    chk({tag, " act bank"}, 128'(bank_sel), 128'(1) << b);
    chk({tag, " act row"}, row_sel, 128'(1) << r);
    chk({tag, " act col"}, 128'(col_sel), 128'(1) << c);
    chk({tag, " act strobes"}, 128'({bank_rw, buf_rw, dut.drv_en}), 128'(0));
    #(dly);
    chk({tag, " act hold"}, 128'(cmd_req), 128'(1));
    cmd_ack = 1'b1;
    wait_req(1'b0, {tag, " act rel"});
    chk({tag, " act rel cmd"}, 128'(cmd), 128'(2'b01));
    #(dly);
    chk({tag, " act rel hold"}, 128'(cmd_req), 128'(0));
    cmd_ack = 1'b0;
    wait_req(1'b1, {tag, " rw"});
    if (wr) begin
      chk({tag, " wr cmd"}, 128'(cmd), 128'(2'b11));
      chk({tag, " wr data"}, 128'(dram_data), 128'(wd));
      chk({tag, " wr strobes"}, 128'({bank_rw, buf_rw}), 128'(2'b11));
      bank_mem[key] = dram_data;
    end else begin
      chk({tag, " rd cmd"}, 128'(cmd), 128'(2'b10));
      chk({tag, " rd strobes"}, 128'({bank_rw, buf_rw, dut.drv_en}), 128'(0));
      tb_dat = bank_mem[key];
      tb_drv = 1'b1;
    end
    #(dly);
    chk({tag, " rw hold"}, 128'(cmd_req), 128'(1));
    cmd_ack = 1'b1;
    wait_req(1'b0, {tag, " rw rel"});
    if (wr) chk({tag, " wr rel"}, 128'({dram_data, bank_rw, buf_rw}), 128'({wd, 2'b11}));
    else    chk({tag, " rd rsp"}, 128'(l2_rsp_data), 128'(tb_dat));
    #(dly);
    chk({tag, " rw rel hold"}, 128'(cmd_req), 128'(0));
    cmd_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tb_drv = 1'b0;
    chk({tag, " idle ctl"}, 128'({cmd_req, cmd, bank_rw, buf_rw, dut.drv_en}), 128'(0));
    chk({tag, " idle sel"}, 128'({bank_sel, col_sel}) | row_sel, 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b1; cmd_ack = 1'b0; tb_drv = 1'b0; tb_dat = 8'h00;
    l2_rw_req = 1'b0; l2_req_instr = 22'h0; l2_req_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset ctl", 128'({cmd_req, cmd, bank_rw, buf_rw, dut.drv_en}), 128'(0));
    chk("reset sel", 128'({bank_sel, col_sel}) | row_sel, 128'(0));
    chk("reset rsp", 128'(l2_rsp_data), 128'(0));
    chk("reset empty", 128'(dut.empty), 128'(1));
    rst_b = 1'b0;

    // Reset while ACTIVATE is outstanding.
    @(posedge clk); #1;
    l2_rw_req = 1'b1; l2_req_instr = 22'h00005; l2_req_data = 8'h11;
    wait_req(1'b1, "pre-reset");
    chk("pre-reset cmd", 128'(cmd), 128'(2'b01));
    rst_b = 1'b1;
    #1;
    chk("async reset req", 128'(cmd_req), 128'(0));
    chk("async reset sel", 128'(bank_sel), 128'(0));
    l2_req_instr = 22'h0;
    @(posedge clk); #1;
    chk("reset state", 128'(dut.state_q), 128'(3'd0));
    chk("reset fifo", 128'(dut.empty), 128'(1));
    chk("reset outs", 128'({cmd_req, cmd, bank_sel, col_sel}) | row_sel, 128'(0));
    @(negedge clk);
    rst_b = 1'b0;

    // Single write: bank 3, row 1, col 3.
    @(posedge clk); #1;
    l2_rw_req = 1'b1; l2_req_instr = 22'h00C0B; l2_req_data = 8'hA5;
    wait_req(1'b1, "w1 hand");
    chk("w1 bank_sel", 128'(bank_sel), 128'(8'h08));
    chk("w1 row_sel", row_sel, 128'h2);
    chk("w1 col_sel", 128'(col_sel), 128'(8'h08));
    serve(22'h00C0B, 1'b1, 8'hA5, 28, "w1");

    // Read back the same address (upper address bits differ and are ignored).
    @(posedge clk); #1;
    l2_rw_req = 1'b0; l2_req_instr = 22'h40C0B; l2_req_data = 8'h00;
    serve(22'h40C0B, 1'b0, 8'h00, 8, "r1");
    chk("r1 rsp value", 128'(l2_rsp_data), 128'(8'hA5));

    // Instruction held for 10 cycles enqueues once.
    base = wr_cnt;
    @(posedge clk); #1;
    l2_rw_req = 1'b1; l2_req_instr = 22'h00123; l2_req_data = 8'h3C;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    chk("hold wr_en pulses", 128'(wr_cnt - base), 128'(1));
    serve(22'h00123, 1'b1, 8'h3C, 8, "hold");

    // Stall the FSM in ACT, then offer 20 distinct requests back to back.
    @(posedge clk); #1;
    l2_req_instr = 22'h00200; l2_req_data = 8'h77;
    wait_req(1'b1, "stall");
    base = wr_cnt;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      l2_req_instr = 22'h01000 + 22'(k * 9);
      l2_req_data  = 8'(8'h80 + k);
    end
    @(negedge clk); #1;
    chk("fill captured", 128'(wr_cnt - base), 128'(16));
    chk("fill full", 128'(dut.full), 128'(1));
    chk("fill wr_en low", 128'(dut.wr_en), 128'(0));
    serve(22'h00200, 1'b1, 8'h77, 8, "stall");
    for (int k = 0; k < 16; k++)
      serve(22'h01000 + 22'(k * 9), 1'b1, 8'(8'h80 + k), 8, $sformatf("fifo%0d", k));
    serve(22'h01000 + 22'(19 * 9), 1'b1, 8'h93, 8, "late");
    chk("late captured", 128'(wr_cnt - base), 128'(17));
    chk("drained", 128'(dut.empty), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
